// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular FIFO with delay-slot tracking.
// Optional same-cycle empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module if_id_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned EXC_W   = 9,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enq_valid,
    output logic               enq_ready,
    input  logic [INSTR_W-1:0] enq_instr,
    input  logic [PC_W-1:0]    enq_pcplus4,
    input  logic [EXC_W-1:0]   enq_except,
    output logic               deq_valid,
    input  logic               deq_ready,
    output logic [INSTR_W-1:0] deq_instr,
    output logic [PC_W-1:0]    deq_pcplus4,
    output logic [EXC_W-1:0]   deq_except,
    output logic               deq_in_delay_slot,
    input  logic               branch_d,
    input  logic               flush,
    output logic [CNT_W-1:0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned ENT_W = INSTR_W + PC_W + EXC_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             slot_q, slot_d;

    logic             full, empty, bypass;
    logic             enq_fire, deq_fire, wr_en, pop;
    logic [ENT_W-1:0] enq_entry, head_entry;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign enq_entry = {enq_instr, enq_pcplus4, enq_except};

`ifdef IFQ_BYPASS_EN
    assign bypass = empty && enq_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        enq_ready  = !full;
        deq_valid  = !empty || bypass;
        head_entry = bypass ? enq_entry : mem_q[rd_ptr_q];
        if (!deq_valid) begin
            head_entry = '0;
        end
        {deq_instr, deq_pcplus4, deq_except} = head_entry;
        deq_in_delay_slot = slot_q && deq_valid;
        count             = count_q;
    end

    // A bypassed entry consumed the same cycle is never written and never popped.
    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;
    assign wr_en    = enq_fire && !flush && !(bypass && deq_ready);
    assign pop      = deq_fire && !flush && !bypass;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        slot_d   = slot_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            slot_d   = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
            if (deq_fire) begin
                slot_d = branch_d;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
        end
    end

    // Storage needs no reset; stale entries are never visible through count.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= enq_entry;
        end
    end

endmodule
